vg93_mfm_rdgen: RTL and testbench
=================================

// Module: vg93_mfm_rdgen
// PURPOSE
//  Disk-side MFM serializer: turns a byte stream into the active-low raw read pulse
//  train (rdat_n) that the vg93 read-clock recovery (RAWR/RCLK PLL) and the VG93 consume.
//  Used by the floppy emulator to play back track images at double density: 250 kbit/s,
//  4 us bit cell, 2 us half-cell = 56 fclk.
//  Supports A1 and C2 missing-clock sync marks and 0x4E gap fill on underrun.
// PARAMETERS
//  HALFCELL  56  fclk cycles per MFM half-cell (clock or data window); must be > PULSE_W
//  PULSE_W   8   fclk cycles rdat_n is held low per flux pulse (~285 ns)
//  FILLER    8'h4E  byte emitted when no input byte is ready at a byte boundary
// PORTS
//  fclk        in   1  28 MHz fpga clock
//  rst_n       in   1  asynchronous active-low reset
//  enable      in   1  1 = stream running; 0 = stop immediately, rdat_n idle
//  din         in   8  next byte, MSB first on disk
//  din_mark    in   2  00 normal, 01 A1-type (drop clock of bit 2), 10 C2-type (drop clock of bit 3), 11 = normal
//  din_valid   in   1  din/din_mark valid
//  din_ready   out  1  holding register empty; transfer on din_valid & din_ready at posedge fclk
//  rdat_n      out  1  raw read data, low = flux pulse (registered)
//  byte_stb    out  1  1-cycle pulse when a byte (input or filler) starts serializing
//  underrun    out  1  1-cycle pulse, coincident with byte_stb, when FILLER was used
// BEHAVIOUR
//  Reset: rdat_n=1, din_ready=1, byte_stb=0, underrun=0, hold empty, prev_bit=0, counters 0.
//  Holding reg: one entry {byte,mark}. din_ready = ~hold_full; same-cycle load and drain is legal,
//   and hold stays full if written as it drains.
//  Byte boundary: first enabled cycle after enable rises, then every 16*HALFCELL cycles.
//   The boundary loads the shifter from hold if full (hold emptied); else loads FILLER with mark=00
//   and pulses underrun. byte_stb pulses on every boundary.
//  Encoding per data bit b (b7 first), two half-cells in order clock, data:
//   clock half = ~prev_bit & ~b, forced 0 for bit 2 if mark=01 and for bit 3 if mark=10.
//   data half = b.
//   prev_bit <= b at the end of each bit; it carries across byte boundaries.
//  Pulse: a half-cell counter hc runs 0..HALFCELL-1. rdat_n <= ~(cellbit & (hc < PULSE_W)).
//   rdat_n falls 1 cycle after the half-cell starts and stays low exactly PULSE_W cycles.
//  Results: A1 mark -> 0x4489; C2 mark -> 0x5224; 0x4E after prev 0 -> 0x9254.
//   A 1 bit in a pattern is a pulse, 0 is no pulse, MSB first.
//  Sequential shape: counters hc, half-cell index 0..15, 8-bit shifter, 2-bit mark, prev_bit.
//   Effectively states IDLE (enable=0) and RUN.
//  enable=0 (any time, incl. mid-byte or mid-pulse): next cycle rdat_n=1, counters 0, prev_bit=0,
//   byte in shifter discarded, no byte_stb/underrun. Hold contents and the din handshake are unaffected.
//  enable 0->1 at edge N: byte boundary processed at edge N+1; first pulse (if any) drives rdat_n low after edge N+2.
//  Reset mid-operation: all state returns to reset values asynchronously; a held byte is lost.
//  Simultaneous boundary and din transfer: the boundary takes the old hold content if full, and the new
//   byte enters hold. If hold was empty, the filler is used and the new byte waits for the next boundary.
// TESTING
//  1 reset, enable=0, din_valid toggling -> rdat_n=1, byte_stb=0; first valid accepted, din_ready=0 until enable.
//  2 enable, stream 0x00 x4 -> one pulse per 112 clk, in the clock half (clk 0-7 of each bit),
//    each 8 clk low; byte_stb every 896 clk.
//  3 stream 0xFF -> pulses at data half offset 56, period 112; no clock pulses.
//  4 0x00 then din=A1 mark=01 -> pattern 0x4489 (pulses at half-cells 1,5,8,12,15).
//    Then C2 mark=10 after 0x00 -> 0x5224.
//  5 no din_valid for 2 boundaries -> underrun+byte_stb pulses twice; output 0x9254 per byte
//    (prev 0); next valid byte is used at the next boundary.
//  6 drop enable mid-pulse at half-cell 9 -> rdat_n=1 next cycle; re-enable -> the byte restarts at b7 with
//    prev_bit=0; hold byte preserved; async reset mid-byte -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/vg93_mfm_rdgen.sv
`default_nettype none
// ============================================================================
// Module  : vg93_mfm_rdgen
// Brief   : MFM serializer producing the active-low raw read pulse train for
//           the vg93 read path, with A1/C2 sync marks and 0x4E gap fill.
// Rev     : 1.0 - initial release
// ============================================================================
module vg93_mfm_rdgen #(
    parameter int         HALFCELL = 56,
    parameter int         PULSE_W  = 8,
    parameter logic [7:0] FILLER   = 8'h4E
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] din,
    input  logic [1:0] din_mark,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       rdat_n,
    output logic       byte_stb,
    output logic       underrun
);

    localparam int                c_HC_W    = $clog2(HALFCELL);
    localparam logic [c_HC_W-1:0] c_HC_LAST = c_HC_W'(HALFCELL - 1);
    localparam logic [c_HC_W-1:0] c_PULSE   = c_HC_W'(PULSE_W);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [c_HC_W-1:0] r_hc;
    logic [3:0]        r_idx;
    logic [7:0]        r_shift;
    logic [1:0]        r_mark;
    logic              r_prev;
    logic              r_hold_full;
    logic [7:0]        r_hold_byte;
    logic [1:0]        r_hold_mark;
    logic              r_rdat_n;
    logic              r_byte_stb;
    logic              r_underrun;

    logic [2:0] w_bit_sel;
    logic       w_bit;
    logic       w_drop;
    logic       w_clk;
    logic       w_cellbit;
    logic       w_hc_last;
    logic       w_boundary;
    logic       w_take;

    // Even half-cell index is the clock window, odd is the data window of bit 7-idx/2.
    assign w_bit_sel  = 3'd7 - r_idx[3:1];
    assign w_bit      = r_shift[w_bit_sel];
    assign w_drop     = ((r_mark == 2'b01) && (w_bit_sel == 3'd2)) ||
                        ((r_mark == 2'b10) && (w_bit_sel == 3'd3));
    assign w_clk      = ~r_prev & ~w_bit & ~w_drop;
    assign w_cellbit  = r_idx[0] ? w_bit : w_clk;
    assign w_hc_last  = (r_hc == c_HC_LAST);
    assign w_boundary = enable & ((r_state == c_ST_IDLE) | (w_hc_last & (r_idx == 4'd15)));
    assign w_take     = din_valid & ~r_hold_full;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_hc        <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_mark      <= '0;
            r_prev      <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_byte <= '0;
            r_hold_mark <= '0;
            r_rdat_n    <= 1'b1;
            r_byte_stb  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            r_underrun <= 1'b0;

            // The holding register keeps running while the stream is stopped.
            if (w_take) begin
                r_hold_full <= 1'b1;
                r_hold_byte <= din;
                r_hold_mark <= din_mark;
            end else if (w_boundary && r_hold_full) begin
                r_hold_full <= 1'b0;
            end

            if (!enable) begin
                r_state  <= c_ST_IDLE;
                r_hc     <= '0;
                r_idx    <= '0;
                r_prev   <= 1'b0;
                r_rdat_n <= 1'b1;
            end else begin
                if (r_state == c_ST_RUN) begin
                    r_rdat_n <= ~(w_cellbit & (r_hc < c_PULSE));
                    r_hc     <= w_hc_last ? '0 : r_hc + 1'b1;
                    if (w_hc_last) begin
                        r_idx <= r_idx + 4'd1;
                        if (r_idx[0]) begin
                            r_prev <= w_bit;
                        end
                    end
                end else begin
                    r_rdat_n <= 1'b1;
                end

                if (w_boundary) begin
                    r_state    <= c_ST_RUN;
                    r_hc       <= '0;
                    r_idx      <= '0;
                    r_byte_stb <= 1'b1;
                    if (r_hold_full) begin
                        r_shift <= r_hold_byte;
                        r_mark  <= r_hold_mark;
                    end else begin
                        r_shift    <= FILLER;
                        r_mark     <= 2'b00;
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

    assign din_ready = ~r_hold_full;
    assign rdat_n    = r_rdat_n;
    assign byte_stb  = r_byte_stb;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vg93_mfm_rdgen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vg93_mfm_rdgen
// Brief   : Self-checking bench for vg93_mfm_rdgen with a pattern-level model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_vg93_mfm_rdgen;

    localparam int HC       = 56;
    localparam int PW       = 8;
    localparam int BYTE_CYC = 16 * HC;
    localparam int BUDGET   = 3 * BYTE_CYC;

    logic       fclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic [7:0] din       = 8'h00;
    logic [1:0] din_mark  = 2'b00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       rdat_n;
    logic       byte_stb;
    logic       underrun;

    vg93_mfm_rdgen #(.HALFCELL(HC), .PULSE_W(PW), .FILLER(8'h4E)) dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .din       (din),
        .din_mark  (din_mark),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .rdat_n    (rdat_n),
        .byte_stb  (byte_stb),
        .underrun  (underrun)
    );

    always #18 fclk = ~fclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Flux pattern of one byte: a 1 is a pulse, clock window first, MSB first.
    function automatic logic [15:0] mfm(input logic [7:0] b, input logic [1:0] mark, input logic prev);
        logic [15:0] p;
        logic        pv;
        logic        c;
        p  = '0;
        pv = prev;
        for (int i = 7; i >= 0; i--) begin
            c = !pv && !b[i];
            if ((mark == 2'd1 && i == 2) || (mark == 2'd2 && i == 3)) c = 1'b0;
            p  = {p[13:0], c, b[i]};
            pv = b[i];
        end
        return p;
    endfunction

    // Model: position within the current byte plus its whole flux pattern.
    bit          m_run;
    int          m_t;
    logic [15:0] m_pat;
    bit          m_hfull;
    logic [7:0]  m_hbyte;
    logic [1:0]  m_hmark;
    logic        e_rdat, e_stb, e_und;

    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_pat = '0; m_hfull = 0;
            e_rdat = 1'b1; e_stb = 1'b0; e_und = 1'b0;
        end else begin
            bit         take;
            logic       prev;
            logic [7:0] nb;
            logic [1:0] nm;
            take  = din_valid && !m_hfull;
            e_stb = 1'b0;
            e_und = 1'b0;
            if (!enable) begin
                m_run  = 0;
                e_rdat = 1'b1;
            end else begin
                e_rdat = 1'b1;
                if (m_run) e_rdat = !(m_pat[15 - m_t / HC] && ((m_t % HC) < PW));
                if (!m_run || m_t == BYTE_CYC - 1) begin
                    prev = m_run ? m_pat[0] : 1'b0;
                    if (m_hfull) begin
                        nb = m_hbyte; nm = m_hmark; m_hfull = 0;
                    end else begin
                        nb = 8'h4E; nm = 2'b00; e_und = 1'b1;
                    end
                    m_pat = mfm(nb, nm, prev);
                    m_t   = 0;
                    m_run = 1;
                    e_stb = 1'b1;
                end else begin
                    m_t++;
                end
            end
            if (take) begin
                m_hfull = 1; m_hbyte = din; m_hmark = din_mark;
            end
        end
    end

    always @(negedge fclk) begin
        if (rst_n)
            check("cycle", {12'h0, rdat_n, byte_stb, underrun, din_ready},
                  {12'h0, e_rdat, e_stb, e_und, !m_hfull});
    end

    // Monitor: decodes the pulse train back into 16-bit patterns per byte.
    int          cyc = 0;
    int          n_stb = 0, n_und = 0, n_cap = 0;
    int          stb_cyc [32];
    logic [15:0] caps [32];
    bit          cap_act = 0;
    int          cap_t = 0;
    logic [15:0] cap_bits = '0;
    int          first_low = -1, first_run = -1, low_run = 0;

    always @(posedge fclk) cyc++;

    always @(negedge fclk) begin
        int k;
        if (rst_n && byte_stb) begin
            if (n_stb < 32) stb_cyc[n_stb] = cyc;
            n_stb++;
        end
        if (rst_n && underrun) n_und++;
        if (rst_n && !rdat_n) begin
            if (first_low < 0) first_low = cyc;
            low_run++;
        end else begin
            if (low_run > 0 && first_run < 0) first_run = low_run;
            low_run = 0;
        end
        if (!rst_n || !enable) begin
            cap_act = 0;
        end else if (byte_stb) begin
            cap_act = 1; cap_t = 0; cap_bits = '0;
        end else if (cap_act) begin
            cap_t++;
            k = cap_t - 1;
            if (k % HC == 3) cap_bits = {cap_bits[14:0], !rdat_n};
            if (k == 15 * HC + 3) begin
                if (n_cap < 32) caps[n_cap] = cap_bits;
                n_cap++;
                cap_act = 0;
            end
        end
    end

    task automatic push(input logic [7:0] b, input logic [1:0] m);
        int w;
        w = 0;
        while (!din_ready && w < BUDGET) begin
            @(posedge fclk); #1; w++;
        end
        check("push_ready", {15'h0, din_ready}, 16'h1);
        din = b; din_mark = m; din_valid = 1'b1;
        @(posedge fclk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_stb(input int target);
        int w;
        w = 0;
        while (n_stb < target && w < BUDGET) begin
            @(negedge fclk); #1; w++;
        end
        check("wait_stb", {15'h0, n_stb >= target}, 16'h1);
    endtask

    int en_cyc;

    initial begin
        int w;
        repeat (4) @(posedge fclk);
        #1;
        check("rst_outputs", {12'h0, rdat_n, byte_stb, underrun, din_ready}, 16'h9);
        rst_n = 1'b1;
        repeat (3) @(posedge fclk);
        #1;

        // Stopped stream: first byte is held, later valids are ignored.
        push(8'h00, 2'b00);
        din = 8'h33; din_valid = 1'b1; @(posedge fclk); #1;
        din_valid = 1'b0; @(posedge fclk); #1;
        din_valid = 1'b1; @(posedge fclk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge fclk);
        #1;
        check("idle_hold_full", {15'h0, din_ready}, 16'h0);
        check("idle_rdat", {15'h0, rdat_n}, 16'h1);

        enable = 1'b1;
        en_cyc = cyc;
        push(8'h00, 2'b00); push(8'h00, 2'b00); push(8'h00, 2'b00);
        push(8'hFF, 2'b00); push(8'hFF, 2'b00);
        push(8'h00, 2'b00); push(8'hA1, 2'b01);
        push(8'h00, 2'b00); push(8'hC2, 2'b10);

        w = 0;
        while (n_und < 2 && w < BUDGET) begin
            @(posedge fclk); #1; w++;
        end
        check("two_underruns", n_und[15:0], 16'd2);
        push(8'h55, 2'b00);
        push(8'hFF, 2'b00);

        // Stop in the middle of the half-cell 9 pulse of the 0xFF byte.
        wait_stb(14);
        repeat (9 * HC + 4) @(posedge fclk);
        #1;
        check("pulse_before_drop", {15'h0, rdat_n}, 16'h0);
        enable = 1'b0;
        @(posedge fclk); #1;
        check("rdat_after_drop", {15'h0, rdat_n}, 16'h1);
        push(8'hA1, 2'b01);
        repeat (20) @(posedge fclk);
        #1;
        check("hold_kept", {15'h0, din_ready}, 16'h0);
        enable = 1'b1;
        wait_stb(15);
        push(8'h00, 2'b00);
        wait_stb(16);
        push(8'h00, 2'b00);
        repeat (300) @(posedge fclk);
        #1;
        check("pre_reset_full", {15'h0, din_ready}, 16'h0);
        @(negedge fclk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {12'h0, rdat_n, byte_stb, underrun, din_ready}, 16'h9);
        enable = 1'b0;
        @(posedge fclk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge fclk);
        #1;

        check("mfm_A1", mfm(8'hA1, 2'd1, 1'b0), 16'h4489);
        check("mfm_C2", mfm(8'hC2, 2'd2, 1'b0), 16'h5224);
        check("mfm_4E", mfm(8'h4E, 2'd0, 1'b0), 16'h9254);
        check("mfm_00", mfm(8'h00, 2'd0, 1'b0), 16'hAAAA);

        check("n_cap", n_cap[15:0], 16'd14);
        check("cap0_00", caps[0], 16'hAAAA);
        check("cap3_00", caps[3], 16'hAAAA);
        check("cap4_FF", caps[4], 16'h5555);
        check("cap5_FF", caps[5], 16'h5555);
        check("cap6_00_after_1", caps[6], 16'h2AAA);
        check("cap7_A1", caps[7], 16'h4489);
        check("cap8_00_after_A1", caps[8], 16'h2AAA);
        check("cap9_C2", caps[9], 16'h5224);
        check("cap10_fill", caps[10], 16'h9254);
        check("cap11_fill", caps[11], 16'h9254);
        check("cap12_55", caps[12], 16'h9111);
        check("cap13_A1_restart", caps[13], 16'h4489);
        check("first_stb_latency", 16'(stb_cyc[0] - en_cyc), 16'd1);
        check("first_pulse_latency", 16'(first_low - stb_cyc[0]), 16'd1);
        check("first_pulse_width", 16'(first_run), 16'd8);
        check("stb_period", 16'(stb_cyc[1] - stb_cyc[0]), 16'd896);
        check("stb_period_fill", 16'(stb_cyc[11] - stb_cyc[10]), 16'd896);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
